// File: rtl/f_subtractor_serial.sv
// f_subtractor_serial
//   Bit-serial subtractor computing DIFF = A - B - BIN, one bit per clock,
//   LSB first, through a single full-subtractor cell and a borrow flop.
//   The operation takes WIDTH cycles in RUN plus one DONE cycle.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one bit of the difference produced per cycle
//   DONE  | result valid, done pulses for this single cycle
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, wins over all inputs
//   start   in   request, sampled only in IDLE
//   ain     in   minuend, captured on accepted start
//   bin_op  in   subtrahend, captured on accepted start
//   bin     in   borrow-in, captured on accepted start
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse, result valid
//   dout    out  difference mod 2^WIDTH, held until next accepted start
//   bout    out  final borrow-out (unsigned underflow)
//   ovf     out  signed two's-complement overflow
module f_subtractor_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin_op,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell on the current LSBs.
    logic             bit_d;
    logic             bit_br;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;
        bit_br   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
        // New bit enters at the MSB so that after WIDTH shifts the LSB
        // computed first lands in bit 0.
        res_next = {bit_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_d      = ain;
                    b_d      = bin_op;
                    res_d    = '0;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = ain[WIDTH-1];
                    b_msb_d  = bin_op[WIDTH-1];
                    busy_d   = 1'b1;
                    dout_d   = '0;
                    bout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            S_RUN: begin
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                res_d    = res_next;
                borrow_d = bit_br;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the result directly so the outputs
                    // are already valid during the DONE cycle.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    dout_d  = res_next;
                    bout_d  = bit_br;
                    ovf_d   = (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_f_subtractor_serial.sv
module tb_f_subtractor_serial;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] ain8, bop8;
    logic       bin8;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] dout8;

    logic       start4;
    logic [3:0] ain4, bop4;
    logic       bin4;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] dout4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f_subtractor_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ain(ain8), .bin_op(bop8),
        .bin(bin8), .busy(busy8), .done(done8), .dout(dout8), .bout(bout8),
        .ovf(ovf8)
    );

    f_subtractor_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .ain(ain4), .bin_op(bop4),
        .bin(bin4), .busy(busy4), .done(done4), .dout(dout4), .bout(bout4),
        .ovf(ovf4)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit op; checks idle-before-start, latency, and result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input string tag);
        logic [8:0] ref9;
        logic       ref_ovf;
        int         n;
        ref9    = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        ref_ovf = (a[7] != b[7]) && (ref9[7] != a[7]);
        @(negedge clk);
        chk(32'(busy8), 32'd0, {tag, "_idle_busy"});
        ain8 = a; bop8 = b; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n), 32'd9, {tag, "_latency"});
        chk(32'(dout8), 32'(ref9[7:0]), {tag, "_dout"});
        chk(32'(bout8), 32'(ref9[8]), {tag, "_bout"});
        chk(32'(ovf8), 32'(ref_ovf), {tag, "_ovf"});
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        logic [4:0] ref5;
        logic       ref_ovf;
        int         n;
        ref5    = {1'b0, a} - {1'b0, b} - {4'd0, bi};
        ref_ovf = (a[3] != b[3]) && (ref5[3] != a[3]);
        @(negedge clk);
        ain4 = a; bop4 = b; bin4 = bi; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(32'(n), 32'd5, "w4_latency");
        chk(32'({bout4, dout4}), 32'(ref5), "w4_result");
        chk(32'(ovf4), 32'(ref_ovf), "w4_ovf");
    endtask

    initial begin
        int pulses;
        int n;
        rst = 1'b1;
        start8 = 1'b0; ain8 = '0; bop8 = '0; bin8 = 1'b0;
        start4 = 1'b0; ain4 = '0; bop4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        chk(32'(busy8), 32'd0, "rst_busy");
        chk(32'(done8), 32'd0, "rst_done");
        chk(32'(dout8), 32'd0, "rst_dout");
        chk(32'(bout8), 32'd0, "rst_bout");
        chk(32'(ovf8),  32'd0, "rst_ovf");
        rst = 1'b0;

        // Directed vectors (hand-computed expectations inside op8 ref).
        op8(8'h05, 8'h03, 1'b0, "t1");
        chk(32'({bout8, dout8, ovf8}), {22'd0, 1'b0, 8'h02, 1'b0}, "t1_exact");
        @(negedge clk);
        chk(32'(done8), 32'd0, "t1_done_one_cycle");
        op8(8'h03, 8'h05, 1'b0, "t2");
        chk(32'({bout8, dout8, ovf8}), {22'd0, 1'b1, 8'hFE, 1'b0}, "t2_exact");
        op8(8'h80, 8'h01, 1'b0, "t3a");
        chk(32'({bout8, dout8, ovf8}), {22'd0, 1'b0, 8'h7F, 1'b1}, "t3a_exact");
        op8(8'h00, 8'h00, 1'b1, "t3b");
        chk(32'({bout8, dout8, ovf8}), {22'd0, 1'b1, 8'hFF, 1'b0}, "t3b_exact");
        op8(8'h7F, 8'hFF, 1'b0, "t3c");
        chk(32'({bout8, dout8, ovf8}), {22'd0, 1'b1, 8'h80, 1'b1}, "t3c_exact");

        // Start held high through RUN and DONE with different operands.
        @(negedge clk);
        ain8 = 8'h05; bop8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            ain8 = 8'hAA; bop8 = 8'h11; bin8 = 1'b1;
            if (done8) pulses++;
            if (i == 9) chk(32'(dout8), 32'h02, "t4_dout_unchanged");
        end
        @(negedge clk);
        start8 = 1'b0;
        if (done8) pulses++;
        @(negedge clk);
        if (done8) pulses++;
        chk(32'(pulses), 32'd1, "t4_done_pulses");
        chk(32'(busy8), 32'd0, "t4_start_in_done_ignored");
        op8(8'h10, 8'h20, 1'b0, "t4_next");

        // Reset in the middle of an op.
        @(negedge clk);
        ain8 = 8'h55; bop8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(32'(busy8), 32'd0, "t5_busy");
        chk(32'(dout8), 32'd0, "t5_dout");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        chk(32'(pulses), 32'd0, "t5_no_done");
        op8(8'h55, 8'h22, 1'b0, "t5_after");
        chk(32'(dout8), 32'h33, "t5_after_exact");

        // Random back-to-back sweeps.
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), "rnd8");
        for (int i = 0; i < 1000; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        n = 0;
        n = n + 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
